// File: rtl/mem_port_arbiter_pkg.sv
// Shared arbiter definitions: state encodings, default latency, counter sizing helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    localparam int MEM_LATENCY_DEFAULT = 2;
    localparam int PERF_CNT_W          = 32;

    // A single-cycle access still needs a 1-bit counter so the datapath stays uniform.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-macro signals of the unified-memory arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ready;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_stall;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ready;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_stall;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Requesters plus memory macro
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rdata, if_stall, d_ready, d_rdata, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Arbiter
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rdata, if_stall, d_ready, d_rdata, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_stall_counter.sv
// Purpose: 32-bit saturating event counter with synchronous clear and preload.
// Latency: count visible the cycle after the event.
// Backpressure: none; holds at all-ones once saturated.
module stall_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [PERF_CNT_W-1:0] load_val,
    input  logic                  inc,
    output logic [PERF_CNT_W-1:0] cnt
);

    logic [PERF_CNT_W-1:0] cnt_q;
    logic [PERF_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + PERF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between fetch and data ports, data first.
// Latency: request sampled at t -> mem_en from t+1 -> ready pulse at t+MEM_LATENCY.
// Backpressure: losing/waiting port sees stall = req & ~ready; MEM_ARB_PERF_EN adds stall counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] if_stall_cnt,
    output logic [PERF_CNT_W-1:0] d_stall_cnt
`endif
);

    localparam int               CNT_W    = cnt_width(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic last_beat;
    logic if_done;
    logic d_done;
    logic if_stall;
    logic d_stall;

    assign last_beat = (state_q != ARB_IDLE) && (cnt_q == '0);
    assign if_done   = (state_q == ARB_BUSY_I) && last_beat;
    assign d_done    = (state_q == ARB_BUSY_D) && last_beat;

    // On the last beat the finishing port's req is ignored; the other port gets a bubble-free handoff.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (bus.d_req) begin
                    state_d = ARB_BUSY_D;
                    cnt_d   = CNT_LOAD;
                end else if (bus.if_req) begin
                    state_d = ARB_BUSY_I;
                    cnt_d   = CNT_LOAD;
                end
            end
            ARB_BUSY_I: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (bus.d_req) begin
                    state_d = ARB_BUSY_D;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY_D: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (bus.if_req) begin
                    state_d = ARB_BUSY_I;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign if_stall = bus.if_req & ~if_done;
    assign d_stall  = bus.d_req & ~d_done;

    assign bus.if_ready = if_done;
    assign bus.if_rdata = if_done ? bus.mem_rdata : '0;
    assign bus.if_stall = if_stall;

    // Store completions return zero rather than whatever the macro drives.
    assign bus.d_ready  = d_done;
    assign bus.d_rdata  = (d_done && !bus.d_we) ? bus.mem_rdata : '0;
    assign bus.d_stall  = d_stall;

    assign bus.mem_en    = (state_q != ARB_IDLE);
    assign bus.mem_we    = (state_q == ARB_BUSY_D) && bus.d_we;
    assign bus.mem_addr  = (state_q == ARB_BUSY_I) ? bus.if_addr :
                           (state_q == ARB_BUSY_D) ? bus.d_addr  : '0;
    assign bus.mem_wdata = (state_q == ARB_BUSY_D) ? bus.d_wdata : '0;

`ifdef MEM_ARB_PERF_EN
    stall_counter u_if_stall_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (1'b0),
        .load_val ('0),
        .inc      (if_stall),
        .cnt      (if_stall_cnt)
    );

    stall_counter u_d_stall_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (1'b0),
        .load_val ('0),
        .inc      (d_stall),
        .cnt      (d_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle reference model on a MEM_LATENCY=2 instance plus directed checks.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic clk = 1'b0;
    logic rst;
    logic rst1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b  ();
    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] ifc, dc, ifc1, dc1;
    logic        sc_rst, sc_load, sc_inc;
    logic [31:0] sc_val, sc_cnt;

    stall_counter u_sc (
        .clk(clk), .reset(sc_rst), .load(sc_load), .load_val(sc_val), .inc(sc_inc), .cnt(sc_cnt)
    );
`endif

    mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
        .clk(clk), .reset(rst), .bus(b)
`ifdef MEM_ARB_PERF_EN
        , .if_stall_cnt(ifc), .d_stall_cnt(dc)
`endif
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut1 (
        .clk(clk), .reset(rst1), .bus(b1)
`ifdef MEM_ARB_PERF_EN
        , .if_stall_cnt(ifc1), .d_stall_cnt(dc1)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: owner of the memory and the absolute cycle its access began.
    initial begin : model
        int    cyc;
        int    m_port;      // 0 none, 1 fetch, 2 data
        int    m_start;
        bit    busy, last, want_d, want_i;
        longint m_ifc, m_dc;
        cyc = 0; m_port = 0; m_start = 0; m_ifc = 0; m_dc = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            busy = (m_port != 0);
            last = busy && ((cyc - m_start) == L - 1);
            check("m_if_ready", b.if_ready, (m_port == 1) && last);
            check("m_if_rdata", b.if_rdata, ((m_port == 1) && last) ? b.mem_rdata : 32'h0);
            check("m_if_stall", b.if_stall, b.if_req && !((m_port == 1) && last));
            check("m_d_ready",  b.d_ready,  (m_port == 2) && last);
            check("m_d_rdata",  b.d_rdata,  ((m_port == 2) && last && !b.d_we) ? b.mem_rdata : 32'h0);
            check("m_d_stall",  b.d_stall,  b.d_req && !((m_port == 2) && last));
            check("m_mem_en",   b.mem_en,   busy);
            check("m_mem_we",   b.mem_we,   (m_port == 2) && b.d_we);
            check("m_mem_addr", b.mem_addr, (m_port == 1) ? b.if_addr : (m_port == 2) ? b.d_addr : 32'h0);
            check("m_mem_wdata", b.mem_wdata, (m_port == 2) ? b.d_wdata : 32'h0);
`ifdef MEM_ARB_PERF_EN
            check("m_if_stall_cnt", ifc, m_ifc);
            check("m_d_stall_cnt",  dc,  m_dc);
            if (rst) begin
                m_ifc = 0; m_dc = 0;
            end else begin
                if (b.if_req && !((m_port == 1) && last)) m_ifc++;
                if (b.d_req  && !((m_port == 2) && last)) m_dc++;
            end
`endif
            if (rst) begin
                m_port = 0;
            end else if (!busy || last) begin
                want_d = b.d_req  && (m_port != 2);
                want_i = b.if_req && (m_port != 1);
                if (want_d) begin
                    m_port = 2; m_start = cyc + 1;
                end else if (want_i) begin
                    m_port = 1; m_start = cyc + 1;
                end else begin
                    m_port = 0;
                end
            end
            cyc++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        int rk, dk, ik, n_en, n_st, n_we, n_rdy;
        logic [31:0] rd, drd, wd, a2, a4;

        rst = 1'b1; rst1 = 1'b1;
        b.if_req = 0; b.if_addr = 0; b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_wdata = 0; b.mem_rdata = 0;
        b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0; b1.mem_rdata = 0;
`ifdef MEM_ARB_PERF_EN
        sc_rst = 1'b1; sc_load = 1'b0; sc_inc = 1'b0; sc_val = 32'h0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en",   b.mem_en,   0);
        check("rst_if_ready", b.if_ready, 0);
        check("rst_d_ready",  b.d_ready,  0);
        check("rst_mem_addr", b.mem_addr, 0);
        check("rst1_mem_en",  b1.mem_en,  0);
        tick();
        rst = 1'b0; rst1 = 1'b0;
        tick();

        // Single fetch
        b.if_req = 1; b.if_addr = 32'h100; b.mem_rdata = 32'h00500093;
        n_en = 0; n_st = 0; rk = 0; rd = 0;
        for (int k = 1; k <= 8 && rk == 0; k++) begin
            @(negedge clk);
            if (b.mem_en) n_en++;
            if (b.if_stall) n_st++;
            if (b.if_ready) begin rk = k; rd = b.if_rdata; end
        end
        check("t1_ready_cycle", rk, 3);
        check("t1_if_rdata", rd, 32'h00500093);
        check("t1_mem_en_cycles", n_en, 2);
        check("t1_stall_cycles", n_st, 2);
        tick();
        b.if_req = 0;
        tick();

        // Simultaneous requests: data first, then fetch with no bubble
        b.if_req = 1; b.if_addr = 32'h100; b.d_req = 1; b.d_we = 0; b.d_addr = 32'h2000; b.mem_rdata = 32'hCAFE0001;
        dk = 0; ik = 0; n_en = 0; drd = 0; a2 = 0; a4 = 0;
        for (int k = 1; k <= 10 && ik == 0; k++) begin
            @(negedge clk);
            if (b.mem_en) n_en++;
            if (k == 2) a2 = b.mem_addr;
            if (k == 4) a4 = b.mem_addr;
            if (b.if_ready) ik = k;
            if (b.d_ready) begin
                dk = k; drd = b.d_rdata;
                @(posedge clk); #1;
                b.d_req = 0;
            end
        end
        check("t2_d_ready_cycle", dk, 3);
        check("t2_if_ready_cycle", ik, 5);
        check("t2_d_rdata", drd, 32'hCAFE0001);
        check("t2_addr_busy_d", a2, 32'h2000);
        check("t2_addr_busy_i", a4, 32'h100);
        check("t2_mem_en_cycles", n_en, 4);
        tick();
        b.if_req = 0;
        tick();

        // Store
        b.d_req = 1; b.d_we = 1; b.d_addr = 32'h40; b.d_wdata = 32'hDEADBEEF; b.mem_rdata = 32'h12345678;
        dk = 0; n_we = 0; wd = 0; drd = 32'hFFFFFFFF;
        for (int k = 1; k <= 8 && dk == 0; k++) begin
            @(negedge clk);
            if (b.mem_we) n_we++;
            if (k == 2) wd = b.mem_wdata;
            if (b.d_ready) begin dk = k; drd = b.d_rdata; end
        end
        check("t3_d_ready_cycle", dk, 3);
        check("t3_mem_we_cycles", n_we, L);
        check("t3_mem_wdata", wd, 32'hDEADBEEF);
        check("t3_d_rdata_store", drd, 0);
        tick();
        b.d_req = 0; b.d_we = 0; b.d_wdata = 0;
        @(negedge clk);
        check("t3_mem_we_after", b.mem_we, 0);
        tick();

        // Reset on the first BUSY_D cycle, request held through it
        b.d_req = 1; b.d_addr = 32'h80; b.mem_rdata = 32'h5555AAAA;
        n_rdy = 0;
        @(negedge clk);
        if (b.d_ready) n_rdy++;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t4_busy_at_reset", b.mem_en, 1);
        if (b.d_ready) n_rdy++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t4_idle_after_reset", b.mem_en, 0);
        check("t4_no_ready_after_reset", b.d_ready, 0);
        if (b.d_ready) n_rdy++;
        check("t4_no_ready_pulses", n_rdy, 0);
        dk = 0; drd = 0;
        for (int k = 2; k <= 8 && dk == 0; k++) begin
            @(negedge clk);
            if (b.d_ready) begin dk = k; drd = b.d_rdata; end
        end
        check("t4_restart_latency", dk, 3);
        check("t4_restart_rdata", drd, 32'h5555AAAA);
        tick();
        b.d_req = 0;
        tick();

        // MEM_LATENCY=1 under continuous load: strict D,I alternation
        b1.if_req = 1; b1.d_req = 1; b1.if_addr = 32'h10; b1.d_addr = 32'h20; b1.mem_rdata = 32'h77;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("t5_idle_no_ready", {b1.d_ready, b1.if_ready}, 2'b00);
            end else begin
                check("t5_d_ready", b1.d_ready, (k % 2) == 0);
                check("t5_if_ready", b1.if_ready, (k % 2) == 1);
                check("t5_mem_en", b1.mem_en, 1);
                check("t5_mem_addr", b1.mem_addr, ((k % 2) == 0) ? 32'h20 : 32'h10);
                check("t5_rdata", ((k % 2) == 0) ? b1.d_rdata : b1.if_rdata, 32'h77);
            end
        end
        tick();
        b1.if_req = 0; b1.d_req = 0;
        tick();

`ifdef MEM_ARB_PERF_EN
        // Fetch behind back-to-back data: counter delta equals observed stall cycles
        begin
            logic [31:0] c0;
            @(negedge clk);
            c0 = ifc;
            n_st = 0;
            tick();
            b.if_req = 1; b.d_req = 1; b.if_addr = 32'h300; b.d_addr = 32'h400;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (b.if_stall) n_st++;
            end
            tick();
            b.if_req = 0; b.d_req = 0;
            repeat (4) @(negedge clk);
            check("t6_if_stall_cnt_delta", ifc - c0, n_st);
        end
        // Saturation with preload
        tick();
        sc_rst = 1'b0; sc_load = 1'b1; sc_val = 32'hFFFFFFFD;
        tick();
        sc_load = 1'b0; sc_inc = 1'b1;
        @(negedge clk);
        check("t6_preload", sc_cnt, 32'hFFFFFFFD);
        repeat (5) tick();
        @(negedge clk);
        check("t6_saturated", sc_cnt, 32'hFFFFFFFF);
        tick();
        sc_rst = 1'b1;
        tick();
        @(negedge clk);
        check("t6_clear", sc_cnt, 32'h0);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
